branch_resolve_unit: RTL and testbench

//   Execute-side counterpart of the fetch-stage predictor. Records each fetched instruction's

---
 rtl/branch_resolve_unit.sv | 135 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: an in-order queue of fetch predictions, checked against the
// resolved outcome in E to produce redirect/flush, predictor training and branch statistics.
module branch_resolve_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_valid,
  input  logic [XLEN-1:0]  f_pc,
  input  logic             f_pred_taken,
  input  logic [XLEN-1:0]  f_pred_target,
  output logic             q_full,
  input  logic             e_valid,
  input  logic             e_branch,
  input  logic             e_jump,
  input  logic             e_taken,
  input  logic [XLEN-1:0]  e_target,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             upd_valid,
  output logic [XLEN-1:0]  upd_pc,
  output logic             upd_taken,
  output logic [XLEN-1:0]  upd_target,
  output logic             q_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [XLEN-1:0]  pc_mem     [DEPTH];
  logic [XLEN-1:0]  target_mem [DEPTH];
  logic [DEPTH-1:0] taken_mem;

  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  logic             redirect_q, upd_valid_q, upd_taken_q, q_err_q;
  logic [XLEN-1:0]  redirect_pc_q, upd_pc_q, upd_target_q;
  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

  logic             q_empty, push, pop, err, flush, is_cti;
  logic             head_taken, actual_taken, mispredict;
  logic [XLEN-1:0]  head_pc, head_target, actual_pc;

  assign q_full  = (count_q == FullCnt);
  assign q_empty = (count_q == '0);

  // Both queue ports are frozen during the redirect cycle.
  assign push = f_valid & ~q_full & ~redirect_q;
  assign pop  = e_valid & ~q_empty & ~redirect_q;
  assign err  = e_valid & q_empty & ~redirect_q;

  assign head_pc     = pc_mem[rd_ptr_q];
  assign head_target = target_mem[rd_ptr_q];
  assign head_taken  = taken_mem[rd_ptr_q];

  assign is_cti       = e_branch | e_jump;
  assign actual_taken = e_jump | (e_branch & e_taken);
  assign actual_pc    = actual_taken ? e_target : head_pc + XLEN'(4);
  // A non-branch predicted taken lands here too: actual_taken=0 differs from the prediction.
  assign mispredict   = (head_taken != actual_taken) |
                        (actual_taken & (head_target != e_target));
  assign flush        = pop & mispredict;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Everything younger than the mispredicted head is wrong-path, including this cycle's push.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr_q]     <= f_pc;
      target_mem[wr_ptr_q] <= f_pred_target;
      taken_mem[wr_ptr_q]  <= f_pred_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      upd_target_q  <= '0;
      q_err_q       <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      redirect_q    <= flush;
      redirect_pc_q <= flush ? actual_pc : '0;
      upd_valid_q   <= pop & is_cti;
      upd_pc_q      <= (pop & is_cti) ? head_pc : '0;
      upd_taken_q   <= pop & is_cti & actual_taken;
      upd_target_q  <= (pop & is_cti) ? e_target : '0;
      if (err)            q_err_q       <= 1'b1;
      if (pop && is_cti)  branch_cnt_q  <= branch_cnt_q + CNT_W'(1);
      if (flush)          mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign upd_valid   = upd_valid_q;
  assign upd_pc      = upd_pc_q;
  assign upd_taken   = upd_taken_q;
  assign upd_target  = upd_target_q;
  assign q_err       = q_err_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; narrow counters so wrap-around is reachable.
module tb_branch_resolve_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             f_valid, f_pred_taken;
  logic [XLEN-1:0]  f_pc, f_pred_target;
  logic             q_full;
  logic             e_valid, e_branch, e_jump, e_taken;
  logic [XLEN-1:0]  e_target;
  logic             redirect, upd_valid, upd_taken, q_err;
  logic [XLEN-1:0]  redirect_pc, upd_pc, upd_target;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  logic [CNT_W-1:0] exp_br, exp_mis;
  int unsigned      n_checks = 0;
  int unsigned      n_pass   = 0;

  branch_resolve_unit #(
    .DEPTH(DEPTH),
    .XLEN (XLEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .f_valid      (f_valid),
    .f_pc         (f_pc),
    .f_pred_taken (f_pred_taken),
    .f_pred_target(f_pred_target),
    .q_full       (q_full),
    .e_valid      (e_valid),
    .e_branch     (e_branch),
    .e_jump       (e_jump),
    .e_taken      (e_taken),
    .e_target     (e_target),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .q_err        (q_err),
    .branch_cnt   (branch_cnt),
    .mispred_cnt  (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_valid = 1'b0; f_pc = '0; f_pred_taken = 1'b0; f_pred_target = '0;
    e_valid = 1'b0; e_branch = 1'b0; e_jump = 1'b0; e_taken = 1'b0; e_target = '0;
  endtask

  task automatic set_push(input logic [XLEN-1:0] pc, input logic tk, input logic [XLEN-1:0] tgt);
    f_valid = 1'b1; f_pc = pc; f_pred_taken = tk; f_pred_target = tgt;
  endtask

  task automatic set_pop(input logic br, input logic jmp, input logic tk,
                         input logic [XLEN-1:0] tgt);
    e_valid = 1'b1; e_branch = br; e_jump = jmp; e_taken = tk; e_target = tgt;
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input logic tk, input logic [XLEN-1:0] tgt);
    set_push(pc, tk, tgt);
    step();
    idle();
  endtask

  task automatic pop(input logic br, input logic jmp, input logic tk, input logic [XLEN-1:0] tgt);
    set_pop(br, jmp, tk, tgt);
    step();
    idle();
  endtask

  // Checks the cycle after a pop; expected counters advance from the hand-given flags.
  task automatic chk_pop(input string tag, input logic rd, input logic [XLEN-1:0] rpc,
                         input logic uv, input logic [XLEN-1:0] upc, input logic ut,
                         input logic [XLEN-1:0] utgt);
    if (uv) exp_br++;
    if (rd) exp_mis++;
    check({tag, ".redirect"}, 64'(redirect), 64'(rd));
    check({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(rpc));
    check({tag, ".upd_valid"}, 64'(upd_valid), 64'(uv));
    if (uv) begin
      check({tag, ".upd_pc"}, 64'(upd_pc), 64'(upc));
      check({tag, ".upd_taken"}, 64'(upd_taken), 64'(ut));
      check({tag, ".upd_target"}, 64'(upd_target), 64'(utgt));
    end
    check({tag, ".branch_cnt"}, 64'(branch_cnt), 64'(exp_br));
    check({tag, ".mispred_cnt"}, 64'(mispred_cnt), 64'(exp_mis));
  endtask

  initial begin
    logic [XLEN-1:0] exp_pc [$];
    idle();
    rst = 1'b1;
    exp_br = '0;
    exp_mis = '0;
    step();
    step();
    rst = 1'b0;
    check("rst.redirect", 64'(redirect), 64'd0);
    check("rst.upd_valid", 64'(upd_valid), 64'd0);
    check("rst.q_full", 64'(q_full), 64'd0);
    check("rst.q_err", 64'(q_err), 64'd0);
    check("rst.branch_cnt", 64'(branch_cnt), 64'd0);
    check("rst.mispred_cnt", 64'(mispred_cnt), 64'd0);

    // Correctly predicted not-taken branch.
    push(32'h100, 1'b0, 32'h0);
    pop(1'b1, 1'b0, 1'b0, 32'h140);
    chk_pop("t1", 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h140);
    step();
    check("t1.upd_pulse", 64'(upd_valid), 64'd0);

    // Predicted NT, actually taken; the push in the redirect cycle must be dropped.
    push(32'h200, 1'b0, 32'h0);
    pop(1'b1, 1'b0, 1'b1, 32'h240);
    chk_pop("t2", 1'b1, 32'h240, 1'b1, 32'h200, 1'b1, 32'h240);
    push(32'h900, 1'b0, 32'h0);
    check("t2.redirect_pulse", 64'(redirect), 64'd0);
    push(32'h210, 1'b0, 32'h0);
    pop(1'b1, 1'b0, 1'b0, 32'h0);
    chk_pop("t2.after", 1'b0, 32'h0, 1'b1, 32'h210, 1'b0, 32'h0);

    // Predicted taken but not taken; then a jump whose target differs from the prediction.
    push(32'h300, 1'b1, 32'h380);
    pop(1'b1, 1'b0, 1'b0, 32'h380);
    chk_pop("t3a", 1'b1, 32'h304, 1'b1, 32'h300, 1'b0, 32'h380);
    step();
    push(32'h400, 1'b1, 32'h500);
    pop(1'b0, 1'b1, 1'b0, 32'h520);
    chk_pop("t3b", 1'b1, 32'h520, 1'b1, 32'h400, 1'b1, 32'h520);
    step();

    // Fill, overflow attempt, blocked push on full pop, then wrap with simultaneous push/pop.
    for (int i = 0; i < 4; i++) begin
      check("t4.not_full", 64'(q_full), 64'd0);
      push(32'hA00 + 32'(4 * i), 1'b0, 32'h0);
    end
    check("t4.full", 64'(q_full), 64'd1);
    push(32'hBAD, 1'b0, 32'h0);
    check("t4.still_full", 64'(q_full), 64'd1);
    set_push(32'hB00, 1'b0, 32'h0);
    pop(1'b1, 1'b0, 1'b0, 32'h0);
    chk_pop("t4.fullpop", 1'b0, 32'h0, 1'b1, 32'hA00, 1'b0, 32'h0);
    check("t4.after_fullpop", 64'(q_full), 64'd0);
    exp_pc = '{32'hA04, 32'hA08, 32'hA0C};
    for (int i = 0; i < 7; i++) begin
      exp_pc.push_back(32'hC00 + 32'(4 * i));
      set_push(32'hC00 + 32'(4 * i), 1'b0, 32'h0);
      pop(1'b1, 1'b0, 1'b0, 32'h0);
      chk_pop("t4.wrap", 1'b0, 32'h0, 1'b1, exp_pc.pop_front(), 1'b0, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      pop(1'b1, 1'b0, 1'b0, 32'h0);
      chk_pop("t4.drain", 1'b0, 32'h0, 1'b1, exp_pc.pop_front(), 1'b0, 32'h0);
    end

    // Non-branch predicted taken; then a pop on an empty queue.
    push(32'h600, 1'b1, 32'h700);
    pop(1'b0, 1'b0, 1'b0, 32'h0);
    chk_pop("t5", 1'b1, 32'h604, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check("t5.q_err_clear", 64'(q_err), 64'd0);
    pop(1'b1, 1'b0, 1'b1, 32'h0);
    chk_pop("t5.empty", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t5.q_err", 64'(q_err), 64'd1);
    step();
    step();
    check("t5.q_err_sticky", 64'(q_err), 64'd1);

    // Reset during a redirect cycle, then reset with a full queue.
    push(32'h700, 1'b0, 32'h0);
    pop(1'b0, 1'b1, 1'b0, 32'h780);
    check("t6.redirect", 64'(redirect), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6.rst_redirect", 64'(redirect), 64'd0);
    check("t6.rst_redirect_pc", 64'(redirect_pc), 64'd0);
    check("t6.rst_upd_valid", 64'(upd_valid), 64'd0);
    check("t6.rst_q_err", 64'(q_err), 64'd0);
    check("t6.rst_branch_cnt", 64'(branch_cnt), 64'd0);
    check("t6.rst_mispred_cnt", 64'(mispred_cnt), 64'd0);
    for (int i = 0; i < 4; i++) push(32'hD00 + 32'(4 * i), 1'b0, 32'h0);
    check("t6.full", 64'(q_full), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6.rst_count", 64'(q_full), 64'd0);

    // Mispredict counter wrap: 15 mispredicts reach the maximum, the 16th wraps to 0.
    for (int i = 0; i < 15; i++) begin
      push(32'hE00, 1'b1, 32'hF00);
      pop(1'b0, 1'b0, 1'b0, 32'h0);
      step();
    end
    check("t6.mis_max", 64'(mispred_cnt), 64'hF);
    push(32'hE00, 1'b1, 32'hF00);
    pop(1'b0, 1'b0, 1'b0, 32'h0);
    check("t6.mis_wrap", 64'(mispred_cnt), 64'h0);
    check("t6.wrap_redirect_pc", 64'(redirect_pc), 64'hE04);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
